// File: rtl/button_debounce_pulse.sv
// Push-button conditioner: two-flop synchronizer, stability-qualified FSM,
// registered debounced level plus one-cycle press/release pulses.
module button_debounce_pulse #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             sync_0;
    logic             sync_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_0 <= 1'b0;
            sync_1 <= 1'b0;
        end else begin
            sync_0 <= btn_raw;
            sync_1 <= sync_0;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (sync_1) begin
                    state_nx = PRESS_CHK;
                    cnt_nx   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync_1) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!sync_1) begin
                    state_nx = RELEASE_CHK;
                    cnt_nx   = '0;
                end
            end
            RELEASE_CHK: begin
                if (sync_1) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they change together
    // with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_pulse   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            btn_level   <= (state_nx == HELD) || (state_nx == RELEASE_CHK);
            btn_pulse   <= (state == PRESS_CHK) && (state_nx == HELD);
            btn_release <= (state == RELEASE_CHK) && (state_nx == IDLE);
        end
    end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse: fixed vector table, directed corner
// sequences and random stimulus against a run-length reference model.
module tb_button_debounce_pulse;

    localparam int SC = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_level;
    logic btn_pulse;
    logic btn_release;

    button_debounce_pulse #(.STABLE_CYCLES(SC), .CNT_W(20)) dut (
        .clk(clk),
        .rst(rst),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_n    = 0;
    int n_pulse  = 0;
    int n_rel    = 0;
    int last_p   = -1;
    int last_r   = -1;

    // Reference: the raw input reaches the decision logic two edges late;
    // the level flips once the delayed input has disagreed with it for
    // SC+1 consecutive edges.
    bit sq[$];
    bit m_level = 1'b0;
    bit m_pulse = 1'b0;
    bit m_rel   = 1'b0;
    int run     = 0;

    always @(posedge clk) begin
        bit s;
        if (rst) begin
            sq = '{1'b0, 1'b0};
            run = 0;
            m_level = 1'b0;
            m_pulse = 1'b0;
            m_rel = 1'b0;
        end else begin
            if (sq.size() != 2) sq = '{1'b0, 1'b0};
            s = sq.pop_front();
            sq.push_back(btn_raw);
            m_pulse = 1'b0;
            m_rel = 1'b0;
            if (s != m_level) begin
                run++;
                if (run == SC + 1) begin
                    m_level = s;
                    m_pulse = s;
                    m_rel = !s;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0b expected %0b",
                     name, cyc_n, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit b);
        rst = r;
        btn_raw = b;
        @(posedge clk);
        #1;
        cyc_n++;
        check("model_level", btn_level, m_level);
        check("model_pulse", btn_pulse, m_pulse);
        check("model_release", btn_release, m_rel);
        check("pulse_release_exclusive", btn_pulse & btn_release, 1'b0);
        if (btn_pulse) begin
            n_pulse++;
            last_p = cyc_n;
        end
        if (btn_release) begin
            n_rel++;
            last_r = cyc_n;
        end
    endtask

    task automatic clear_counts();
        n_pulse = 0;
        n_rel = 0;
        last_p = -1;
        last_r = -1;
    endtask

    typedef struct {
        bit r;
        bit b;
        bit l;
        bit p;
        bit rl;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit b, input bit l,
                                input bit p, input bit rl);
        vec_t v;
        v.r = r; v.b = b; v.l = l; v.p = p; v.rl = rl;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        // Held through reset, then one press after re-qualification.
        add(1, 1, 0, 0, 0);
        add(1, 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0);
        // Clean release.
        for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0);
        // Clean press held 20 cycles.
        for (int i = 0; i < 6; i++) add(0, 1, 0, 0, 0);
        add(0, 1, 1, 1, 0);
        for (int i = 0; i < 13; i++) add(0, 1, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].b);
            check($sformatf("tbl_level[%0d]", i), btn_level, tbl[i].l);
            check($sformatf("tbl_pulse[%0d]", i), btn_pulse, tbl[i].p);
            check($sformatf("tbl_release[%0d]", i), btn_release, tbl[i].rl);
        end

        // Bounce on press.
        for (int i = 0; i < 10; i++) drive(0, 0);
        clear_counts();
        drive(0, 1); drive(0, 1); drive(0, 1); drive(0, 0);
        drive(0, 1); drive(0, 1); drive(0, 0);
        t = cyc_n + 1;
        for (int i = 0; i < 14; i++) drive(0, 1);
        check_int("bounce_pulse_count", n_pulse, 1);
        check_int("bounce_pulse_cycle", last_p, t + 6);

        // Short glitches: 4 samples rejected, 5 accepted.
        for (int i = 0; i < 10; i++) drive(0, 0);
        clear_counts();
        for (int i = 0; i < 4; i++) drive(0, 1);
        for (int i = 0; i < 12; i++) drive(0, 0);
        check_int("glitch4_pulse_count", n_pulse, 0);
        check_int("glitch4_release_count", n_rel, 0);
        clear_counts();
        for (int i = 0; i < 5; i++) drive(0, 1);
        for (int i = 0; i < 3; i++) drive(0, 0);
        check_int("glitch5_pulse_count", n_pulse, 1);

        // Release with bounce.
        for (int i = 0; i < 12; i++) drive(0, 1);
        clear_counts();
        drive(0, 0); drive(0, 1); drive(0, 0);
        t = cyc_n;
        for (int i = 0; i < 12; i++) drive(0, 0);
        check_int("release_count", n_rel, 1);
        check_int("release_cycle", last_r, t + 6);
        check_int("release_no_pulse", n_pulse, 0);

        // Reset in the middle of press qualification.
        for (int i = 0; i < 5; i++) drive(0, 1);
        clear_counts();
        drive(1, 1);
        t = cyc_n + 1;
        for (int i = 0; i < 12; i++) drive(0, 1);
        check_int("midrst_pulse_count", n_pulse, 1);
        check_int("midrst_pulse_cycle", last_p, t + 6);

        // Random segments with occasional reset.
        for (int s = 0; s < 400; s++) begin
            bit b;
            bit r;
            int len;
            b = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            r = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < len; k++) drive(r && (k == 0), b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
Front-end conditioning stage for the lab's two-state toggle machine. It takes a raw, asynchronous, bouncing push-button signal and synchronizes it to `clk`. It then qualifies the signal with a stability counter and produces a clean debounced level plus single-cycle press and release pulses. `btn_pulse` drives the toggle machine's serial `in` input directly, so each physical press produces exactly one input event.

Parameters:
STABLE_CYCLES, 4, consecutive synchronized samples beyond the first that must agree before a level change is accepted; legal range >= 1; board builds use 500000.
CNT_W, 20, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
btn_raw  input  1  raw push-button level; asynchronous to clk and may bounce.
btn_level  output  1  debounced button level; 1 means pressed.
btn_pulse  output  1  one-cycle pulse on each accepted press.
btn_release  output  1  one-cycle pulse on each accepted release.

Behaviour:
- Reset (rst=1 at a clk edge):
  - sync_0, sync_1, counter, btn_level, btn_pulse and btn_release all go to 0.
  - State goes to IDLE.
  - Reset overrides every other event in the same cycle.
- Synchronizer:
  - Two flops, btn_raw -> sync_0 -> sync_1.
  - Only sync_1 is used by the rest of the block.
- FSM has 4 states; counter is cleared on every state change.
  - IDLE (level 0): if sync_1=1, go to PRESS_CHK with counter=0.
  - PRESS_CHK (level 0):
    - sync_1=0 -> back to IDLE (bounce rejected).
    - else if counter = STABLE_CYCLES-1 -> go to HELD.
    - else increment counter.
  - HELD (level 1): if sync_1=0, go to RELEASE_CHK with counter=0.
  - RELEASE_CHK (level 1):
    - sync_1=1 -> back to HELD.
    - else if counter = STABLE_CYCLES-1 -> go to IDLE.
    - else increment counter.
- Outputs are all registered, with no combinational path from btn_raw to any output.
  - btn_level = 1 exactly while state is HELD or RELEASE_CHK.
  - btn_pulse = 1 only in the first cycle after the PRESS_CHK->HELD transition.
  - btn_release = 1 only in the first cycle after the RELEASE_CHK->IDLE transition.
  - btn_pulse and btn_release are never high together.
- Acceptance condition: a press is accepted only after sync_1 has been 1 for STABLE_CYCLES+1 consecutive edges (one edge in IDLE, STABLE_CYCLES edges in PRESS_CHK). Release is symmetric.
- Latency: edge E is the first edge at which btn_raw is sampled 1 and stays 1.
  - btn_level and btn_pulse rise after edge E+2+STABLE_CYCLES.
  - With STABLE_CYCLES=4: E+6, i.e. high on the 7th edge counting E as the 1st.
  - Release latency is identical.
- Boundary conditions:
  - Counter never exceeds STABLE_CYCLES-1; no wrap-around is possible.
  - Any disagreeing sample during a CHK state aborts qualification with no output change.
  - A button held steady through reset produces one press pulse after re-qualification following reset deassertion.
  - Reset mid-qualification discards partial counts.
  - Any pulse in flight is cleared by reset.
- Throughput: at most one btn_pulse per full press/release cycle. Holding the button indefinitely gives exactly one pulse.

Test Plan (STABLE_CYCLES=4):
1. Reset: rst=1 for 2 cycles with btn_raw=1, then rst=0 -> all outputs 0 during reset; one btn_pulse on the 7th edge after deassertion; btn_level stays 1 afterwards.
2. Clean press: btn_raw 0->1, held 20 cycles -> btn_pulse high for exactly 1 cycle, 7 edges after the rise; btn_level 1 from that cycle on; btn_release stays 0.
3. Bounce: btn_raw pattern 1,1,1,0,1,1,0 followed by steady 1 -> no pulse during the bounce; exactly one btn_pulse 7 edges after the final 0->1 transition.
4. Short glitch: btn_raw high for exactly 4 samples, then low -> btn_pulse, btn_level and btn_release all stay 0. Repeat with 5 samples -> one pulse.
5. Release: from HELD, btn_raw 1->0 with a bounce of 0,1,0, then steady 0 -> btn_release one cycle, 7 edges after the final fall; btn_level drops in the same cycle; no extra btn_pulse.
6. Reset mid-qualification: assert rst for 1 cycle while in PRESS_CHK with counter=2, btn_raw kept at 1 -> no pulse until 7 edges after rst deassertion, then exactly one pulse.
